// File: rtl/adder_tree_seq_ctrl.sv
// Issue/return sequencer for the registered INT16 adder tree.
// Tracks in-flight tiles with a latency-matched valid pipe and accumulates sums.
module adder_tree_seq_ctrl #(
  parameter int TREE_LAT = 4,
  parameter int SUM_W    = 16,
  parameter int ACC_W    = 32,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tiles,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tree_en,
  input  logic [SUM_W-1:0] tree_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]        n_reg;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        ret_cnt;
  logic [TREE_LAT-1:0]     vld_pipe;
  logic [TREE_LAT-1:0]     vld_nx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_ext;
  logic                    fire;
  logic                    ret;
  logic                    last_issue;
  logic                    last_ret;
  logic                    hs;

  assign in_ready  = (state == ISSUE);
  assign fire      = in_valid & in_ready;
  assign tree_en   = fire;
  assign out_valid = (state == HOLD);
  assign out_data  = out_valid ? acc : '0;
  assign busy      = (state != IDLE);
  assign hs        = out_valid & out_ready;

  assign sum_ext = ACC_W'($signed(tree_sum));

  // Only tagged tree outputs count; bubbles carry garbage sums.
  assign ret = vld_pipe[TREE_LAT-1]
             & ((state == ISSUE) | (state == DRAIN));

  assign last_issue = fire
                    & ((issue_cnt + CNT_W'(1)) == n_reg);
  assign last_ret   = ret
                    & ((ret_cnt + CNT_W'(1)) == n_reg);

  always_comb begin
    vld_nx    = vld_pipe << 1;
    vld_nx[0] = fire;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (num_tiles == '0) ? HOLD : ISSUE;
        end
      end
      ISSUE: begin
        if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        if (last_ret) state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nx = IDLE;
      end
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      n_reg     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      vld_pipe  <= '0;
      done      <= 1'b0;
    end else if (abort) begin
      acc       <= '0;
      n_reg     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      vld_pipe  <= '0;
      done      <= 1'b0;
    end else begin
      vld_pipe <= vld_nx;
      done     <= hs;
      if ((state == IDLE) && start) begin
        n_reg     <= num_tiles;
        acc       <= '0;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (fire) issue_cnt <= issue_cnt + CNT_W'(1);
        if (ret) begin
          acc     <= acc + sum_ext;
          ret_cnt <= ret_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Directed bench for adder_tree_seq_ctrl with a 4-stage tree model.
// A 16-bit accumulator instance shares stimulus to show wraparound.
module tb_adder_tree_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_tiles;
  logic        abort;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] tile;
  logic [15:0] s0, s1, s2, s3;
  logic [15:0] tree_sum;

  logic        in_ready, tree_en, out_valid, busy, done;
  logic [31:0] out_data;
  logic        in_ready16, tree_en16, out_valid16, busy16, done16;
  logic [15:0] out_data16;

  int total;
  int bad;

  adder_tree_seq_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_tiles (num_tiles),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tree_en   (tree_en),
    .tree_sum  (tree_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  adder_tree_seq_ctrl #(.ACC_W(16)) u_dut16 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_tiles (num_tiles),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .tree_en   (tree_en16),
    .tree_sum  (tree_sum),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .out_data  (out_data16),
    .busy      (busy16),
    .done      (done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tree stand-in: four register levels, no valid, same reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s0 <= tile;
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign tree_sum = s3;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic [7:0] n,
                     input logic iv, input logic [15:0] d,
                     input logic ab, input logic ordy);
    @(posedge clk);
    #1;
    start     = st;
    num_tiles = n;
    in_valid  = iv;
    tile      = d;
    abort     = ab;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    num_tiles = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tile      = 16'h7FFF;
    #3;
    chk("rst busy", 32'(busy), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", out_data, 0);
    chk("rst done", 32'(done), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // single tile
    cyc(1'b1, 8'd1, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    chk("t1 idle busy", 32'(busy), 0);
    cyc(1'b0, 8'd0, 1'b1, 16'd5, 1'b0, 1'b0);
    chk("t1 in_ready", 32'(in_ready), 1);
    chk("t1 tree_en", 32'(tree_en), 1);
    chk("t1 busy", 32'(busy), 1);
    idle(1);
    chk("t1 drain rdy", 32'(in_ready), 0);
    idle(3);
    chk("t1 c4 ov", 32'(out_valid), 0);
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    chk("t1 c5 ov", 32'(out_valid), 1);
    chk("t1 c5 data", out_data, 32'd5);
    idle(1);
    chk("t1 done", 32'(done), 1);
    chk("t1 busy end", 32'(busy), 0);
    idle(1);
    chk("t1 done once", 32'(done), 0);

    // three signed tiles back to back: 100 - 300 + 7 = -193
    cyc(1'b1, 8'd3, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd100, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'hFED4, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd7, 1'b0, 1'b0);
    chk("t2 c2 rdy", 32'(in_ready), 1);
    idle(1);
    chk("t2 c3 rdy", 32'(in_ready), 0);
    idle(3);
    chk("t2 c6 ov", 32'(out_valid), 0);
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    chk("t2 c7 ov", 32'(out_valid), 1);
    chk("t2 c7 data", out_data, 32'hFFFF_FF3F);
    idle(1);
    chk("t2 done", 32'(done), 1);

    // bubbles with garbage sums, then backpressure
    cyc(1'b1, 8'd2, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd10, 1'b0, 1'b0);
    idle(1);
    chk("t3 bubble rdy", 32'(in_ready), 1);
    idle(1);
    cyc(1'b0, 8'd0, 1'b1, 16'd20, 1'b0, 1'b0);
    idle(3);
    idle(1);
    chk("t3 c7 ov", 32'(out_valid), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'd1, 1'b0, 16'h7FFF, 1'b0, 1'b0);
      chk("t3 hold ov", 32'(out_valid), 1);
      chk("t3 hold data", out_data, 32'd30);
    end
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    chk("t3 hs ov", 32'(out_valid), 1);
    chk("t3 hs data", out_data, 32'd30);
    idle(1);
    chk("t3 done", 32'(done), 1);
    chk("t3 busy", 32'(busy), 0);
    chk("t3 ov drop", 32'(out_valid), 0);
    idle(1);
    chk("t3 done once", 32'(done), 0);
    chk("t3 start ignored", 32'(busy), 0);

    // zero-length job
    cyc(1'b1, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    chk("t4 zero ov", 32'(out_valid), 1);
    chk("t4 zero data", out_data, 32'd0);
    chk("t4 zero rdy", 32'(in_ready), 0);
    idle(1);
    chk("t4 zero done", 32'(done), 1);

    // wrap: 3 x 0x7FFF
    cyc(1'b1, 8'd3, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 8'd0, 1'b1, 16'h7FFF, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    chk("t5 ov", 32'(out_valid), 1);
    chk("t5 data32", out_data, 32'h0001_7FFD);
    chk("t5 ov16", 32'(out_valid16), 1);
    chk("t5 data16", 32'(out_data16), 32'h0000_7FFD);
    idle(1);
    chk("t5 done16", 32'(done16), 1);

    // abort with two tiles in flight, then a fresh job
    cyc(1'b1, 8'd4, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd50, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd60, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    cyc(1'b1, 8'd1, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    chk("t6 ab busy", 32'(busy), 0);
    chk("t6 ab rdy", 32'(in_ready), 0);
    chk("t6 ab ov", 32'(out_valid), 0);
    cyc(1'b0, 8'd0, 1'b1, 16'd9, 1'b0, 1'b0);
    chk("t6 new rdy", 32'(in_ready), 1);
    idle(3);
    idle(1);
    chk("t6 c8 ov", 32'(out_valid), 0);
    chk("t6 c8 done", 32'(done), 0);
    cyc(1'b0, 8'd0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    chk("t6 ov", 32'(out_valid), 1);
    chk("t6 data", out_data, 32'd9);
    idle(1);
    chk("t6 done", 32'(done), 1);

    // asynchronous reset mid-drain
    cyc(1'b1, 8'd2, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd1, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 16'd2, 1'b0, 1'b0);
    idle(1);
    chk("t7 drain busy", 32'(busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("t7 rst busy", 32'(busy), 0);
    chk("t7 rst rdy", 32'(in_ready), 0);
    chk("t7 rst ov", 32'(out_valid), 0);
    chk("t7 rst data", out_data, 32'd0);
    chk("t7 rst done", 32'(done), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
